// File: rtl/char_stream_normalizer_pkg.sv
// char_stream_normalizer_pkg: character constants, FSM states and helpers
package char_stream_normalizer_pkg;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SLASH = 8'h2F;

    typedef enum logic [1:0] {ST_TEXT, ST_SLASH, ST_CMT} state_t;

    function automatic logic is_sep(input logic [7:0] c);
        return c == CH_SP || c == CH_TAB || c == CH_LF || c == CH_CR;
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] c, input logic en);
        return (en && c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    endfunction
endpackage

// File: rtl/char_stream_normalizer_if.sv
// char_stream_normalizer_if: byte stream with valid/ready handshake
interface char_stream_normalizer_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    modport master (output valid, data, input ready);
    modport slave  (input valid, data, output ready);
endinterface

// File: rtl/char_stream_normalizer_fifo.sv
// char_fifo: dual-push single-pop FIFO; push1 lands in the slot after push0
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push0_i,
    input  logic                       push1_i,
    input  logic [WIDTH-1:0]           data0_i,
    input  logic [WIDTH-1:0]           data1_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic [WIDTH-1:0]           head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    count_q;

    // storage and pointers; memory is cleared so the head reads 0 after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push0_i) mem_q[wp_q] <= data0_i;
            if (push1_i) mem_q[wp_q + AW'(1)] <= data1_i;
            wp_q    <= wp_q + AW'(push0_i) + AW'(push1_i);
            rp_q    <= rp_q + AW'(pop_i);
            count_q <= count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
        end
    end

    assign count_o = count_q;
    assign empty_o = count_q == '0;
    assign head_o  = mem_q[rp_q];
endmodule

// File: rtl/char_stream_normalizer.sv
// char_stream_normalizer: collapses separators, strips // comments, folds case
module char_stream_normalizer
    import char_stream_normalizer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit FOLD_CASE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    char_stream_normalizer_if.slave    in_if,
    char_stream_normalizer_if.master   out_if
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_q, state_d;
    logic          last_sep_q, last_sep_d;
    logic          push0, push1, pop, empty, acc, sep;
    logic [7:0]    data0, data1, fc, head;
    logic [CW-1:0] count;

    assign in_if.ready  = !flush_i && count <= CW'(DEPTH - 2);
    assign acc          = in_if.valid && in_if.ready;
    assign sep          = is_sep(in_if.data);
    assign fc           = fold(in_if.data, FOLD_CASE);
    assign out_if.valid = !empty;
    assign out_if.data  = head;
    assign pop          = out_if.valid && out_if.ready;

    // next state and FIFO pushes for an accepted byte or a flush
    always_comb begin
        state_d    = state_q;
        last_sep_d = last_sep_q;
        push0      = 1'b0;
        push1      = 1'b0;
        data0      = CH_SP;
        data1      = CH_SP;
        if (acc) begin
            case (state_q)
                ST_TEXT: begin
                    if (in_if.data == CH_SLASH) begin
                        state_d = ST_SLASH;
                    end else if (sep) begin
                        push0      = !last_sep_q;
                        last_sep_d = 1'b1;
                    end else begin
                        push0      = 1'b1;
                        data0      = fc;
                        last_sep_d = 1'b0;
                    end
                end
                ST_SLASH: begin
                    if (in_if.data == CH_SLASH) begin
                        state_d = ST_CMT;
                    end else begin
                        push0      = 1'b1;
                        data0      = CH_SLASH;
                        push1      = 1'b1;
                        data1      = sep ? CH_SP : fc;
                        last_sep_d = sep;
                        state_d    = ST_TEXT;
                    end
                end
                ST_CMT: begin
                    if (in_if.data == CH_LF) begin
                        push0      = !last_sep_q;
                        last_sep_d = 1'b1;
                        state_d    = ST_TEXT;
                    end
                end
                default: state_d = ST_TEXT;
            endcase
        end else if (flush_i) begin
            if (state_q == ST_SLASH && count < CW'(DEPTH)) begin
                push0      = 1'b1;
                data0      = CH_SLASH;
                last_sep_d = 1'b0;
                state_d    = ST_TEXT;
            end else if (state_q == ST_CMT) begin
                state_d = ST_TEXT;
            end
        end
    end

    // FSM state and separator-run flag; nothing pushed yet counts as a separator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_TEXT;
            last_sep_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_sep_q <= last_sep_d;
        end
    end

    char_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push0_i (push0),
        .push1_i (push1),
        .data0_i (data0),
        .data1_i (data1),
        .pop_i   (pop),
        .count_o (count),
        .empty_o (empty),
        .head_o  (head)
    );
endmodule

// File: tb/tb_char_stream_normalizer.sv
// tb_char_stream_normalizer: table vectors, corner sequences and random streams vs a text-level model
module tb_char_stream_normalizer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    char_stream_normalizer_if in_if();
    char_stream_normalizer_if out_if();

    char_stream_normalizer #(.DEPTH(4), .FOLD_CASE(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .in_if   (in_if),
        .out_if  (out_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        string din;
        bit    fl;
        string dexp;
    } vec_t;

    typedef byte bq_t[$];

    function automatic string q2s(input bq_t q);
        string r = "";
        foreach (q[k]) r = $sformatf("%s%c", r, q[k]);
        return r;
    endfunction

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
        return q;
    endfunction

    function automatic bq_t model(input string s);
        bq_t q;
        bit  ls = 1'b1;
        int  i = 0;
        byte c;
        while (i < s.len()) begin
            c = s[i];
            if (c == 8'h2F && i + 1 < s.len() && s[i+1] == 8'h2F) begin
                while (i < s.len() && s[i] != 8'h0A) i++;
            end else begin
                if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D) begin
                    if (!ls) q.push_back(8'h20);
                    ls = 1'b1;
                end else begin
                    q.push_back((c >= 8'h41 && c <= 8'h5A) ? (c + 8'sd32) : c);
                    ls = 1'b0;
                end
                i++;
            end
        end
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkq(input string name, input bq_t got, input bq_t exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, q2s(got), q2s(exp));
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = 8'h00;
        out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run(input string s, input bit fl, input int pv, input int pr, output bq_t got);
        int i = 0;
        int cyc = 0;
        bit fl_done = !fl;
        got = {};
        while ((i < s.len() || !fl_done || out_if.valid) && cyc < 2000) begin
            in_if.valid  = (i < s.len()) && ($urandom_range(99) < pv);
            in_if.data   = (i < s.len()) ? s[i] : 8'h00;
            flush        = (i >= s.len()) && !fl_done && !out_if.valid;
            out_if.ready = $urandom_range(99) < pr;
            @(negedge clk);
            if (in_if.valid && in_if.ready) i++;
            if (flush) fl_done = 1'b1;
            if (out_if.valid && out_if.ready) got.push_back(out_if.data);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_if.valid  = 1'b0;
        flush        = 1'b0;
        out_if.ready = 1'b0;
        if (cyc >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: got %0d cycles expected < 2000", cyc);
        end
    endtask

    initial begin
        vec_t vt[$];
        bq_t  got, got2;
        string s;
        int   acc;
        string abc;
        abc = $sformatf("aZ/ %c%c%cx.B/", 8'h09, 8'h0A, 8'h0D);
        vt.push_back('{"t1_collapse",   "Begin  end",     1'b0, "begin end"});
        vt.push_back('{"t2_leading",    "\t\r\n BEGIN",   1'b0, "begin"});
        vt.push_back('{"t3_comment",    "a//x y\nb",      1'b0, "a b"});
        vt.push_back('{"t4_slash_text", "a/b",            1'b0, "a/b"});
        vt.push_back('{"t4_slash_sep",  "a/ b",           1'b0, "a/ b"});
        vt.push_back('{"t6_flush",      "x/",             1'b1, "x/"});
        vt.push_back('{"cmt_blank",     "A  //c\n\nB",    1'b0, "a b"});
        vt.push_back('{"cmt_only",      "//only",         1'b1, ""});
        vt.push_back('{"slash_tab",     "a/\tb",          1'b0, "a/ b"});
        vt.push_back('{"held_slash",    "ab/",            1'b0, "ab"});
        vt.push_back('{"triple_slash",  "x///y\nz",       1'b0, "x z"});
        vt.push_back('{"sep_cmt_lf",    $sformatf("a%c//c%cb", 8'h0A, 8'h0A), 1'b0, "a b"});
        vt.push_back('{"lead_slash",    "/a",             1'b0, "/a"});
        vt.push_back('{"only_seps",     "  \t",           1'b1, ""});
        vt.push_back('{"punct",         "Q.r,S",          1'b0, "q.r,s"});

        do_reset();
        chk("rst_in_ready", 32'(in_if.ready), 32'd1);
        chk("rst_out_valid", 32'(out_if.valid), 32'd0);
        chk("rst_out_char", 32'(out_if.data), 32'h00);

        foreach (vt[k]) begin
            do_reset();
            run(vt[k].din, vt[k].fl, 100, (k % 2 == 0) ? 100 : 60, got);
            chkq(vt[k].name, got, s2q(vt[k].dexp));
        end

        do_reset();
        s   = "abcd";
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_if.valid = acc < 4;
            in_if.data  = s[acc < 4 ? acc : 3];
            @(negedge clk);
            if (in_if.valid && in_if.ready) acc++;
            @(posedge clk);
            #1;
        end
        in_if.valid = 1'b0;
        chk("t5_accepts", 32'(acc), 32'd3);
        chk("t5_in_ready_low", 32'(in_if.ready), 32'd0);
        chk("t5_head", 32'(out_if.data), 32'h61);
        run("d", 1'b0, 100, 100, got);
        chkq("t5_drain", got, s2q("abcd"));

        do_reset();
        run("x//c", 1'b1, 100, 100, got);
        run("d", 1'b0, 100, 100, got2);
        got = {got, got2};
        chkq("t6_flush_cmt", got, s2q("xd"));

        do_reset();
        s = "beg";
        for (int c = 0; c < 3; c++) begin
            in_if.valid = 1'b1;
            in_if.data  = s[c];
            @(posedge clk);
            #1;
        end
        in_if.valid = 1'b0;
        chk("t6_pre_rst_valid", 32'(out_if.valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_rst_out_valid", 32'(out_if.valid), 32'd0);
        chk("t6_rst_in_ready", 32'(in_if.ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        run("end", 1'b0, 100, 100, got);
        chkq("t6_after_rst", got, s2q("end"));

        for (int r = 0; r < 40; r++) begin
            int len = $urandom_range(30, 1);
            s = "";
            for (int k = 0; k < len; k++)
                s = $sformatf("%s%c", s, abc[$urandom_range(abc.len() - 1)]);
            do_reset();
            run(s, 1'b1, $urandom_range(100, 30), $urandom_range(100, 20), got);
            chkq($sformatf("rand_%0d", r), got, model(s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
